// File: rtl/qpsk_prbs_ber_checker.sv
// Hard-slices QPSK symbols, self-synchronises a local PRBS9 (x^9+x^5+1) to the received
// bit stream, and counts compared bits and bit errors while locked.
`timescale 1ns/1ps
module qpsk_prbs_ber_checker #(
  parameter int DWIDTH         = 16,
  parameter int CNT_WIDTH      = 32,
  parameter int VERIFY_SYMS    = 32,
  parameter int VERIFY_MAX_ERR = 2,
  parameter int LOL_WINDOW     = 64,
  parameter int LOL_MAX_ERR    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DWIDTH-1:0]    in_I,
  input  logic [DWIDTH-1:0]    in_Q,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic [1:0]           state,
  output logic                 err_pulse,
  output logic [CNT_WIDTH-1:0] bit_count,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam int SYMW = $clog2((VERIFY_SYMS > 5) ? VERIFY_SYMS : 5);
  localparam int VW   = $clog2(2 * VERIFY_SYMS + 1);
  localparam int WW   = $clog2(LOL_WINDOW);
  localparam int SW   = $clog2(2 * LOL_WINDOW + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  state_t          state_q, state_nxt;
  logic [8:0]      lfsr, lfsr_nxt;
  logic [SYMW-1:0] sym_cnt, sym_nxt;
  logic [VW-1:0]   verr, verr_nxt, verr_sum;
  logic [WW-1:0]   win_cnt, win_nxt;
  logic [SW-1:0]   win_sum, win_sum_nxt, win_acc;
  logic            count_en, pulse_nxt;

  // Slicer: the sign bit is the hard decision, so the magnitude bits are ignored.
  logic bi, bq, p1, p2;
  logic [1:0] nerr;
  logic [8:0] lfsr_load, lfsr_step;
  wire unused_lsbs = ^{in_I[DWIDTH-2:0], in_Q[DWIDTH-2:0]};

  assign bi        = in_I[DWIDTH-1];
  assign bq        = in_Q[DWIDTH-1];
  assign p1        = lfsr[8] ^ lfsr[4];
  assign p2        = lfsr[7] ^ lfsr[3];
  assign nerr      = {1'b0, bi ^ p1} + {1'b0, bq ^ p2};
  assign lfsr_load = {lfsr[6:0], bi, bq};
  assign lfsr_step = {lfsr[6:0], p1, p2};

  always_comb begin
    state_nxt   = state_q;
    lfsr_nxt    = lfsr;
    sym_nxt     = sym_cnt;
    verr_nxt    = verr;
    verr_sum    = verr + VW'(nerr);
    win_nxt     = win_cnt;
    win_sum_nxt = win_sum;
    win_acc     = win_sum + SW'(nerr);
    count_en    = 1'b0;
    pulse_nxt   = 1'b0;
    if (in_valid) begin
      case (state_q)
        SEARCH: begin
          lfsr_nxt = lfsr_load;
          if (sym_cnt == SYMW'(4)) begin
            sym_nxt = '0;
            // An all-zero seed would lock the LFSR at zero forever.
            if (lfsr_load != 9'd0) begin
              state_nxt = VERIFY;
              verr_nxt  = '0;
            end
          end else begin
            sym_nxt = sym_cnt + SYMW'(1);
          end
        end
        VERIFY: begin
          lfsr_nxt = lfsr_step;
          verr_nxt = verr_sum;
          if (sym_cnt == SYMW'(VERIFY_SYMS - 1)) begin
            sym_nxt = '0;
            if (verr_sum <= VW'(VERIFY_MAX_ERR)) begin
              state_nxt   = LOCKED;
              win_nxt     = '0;
              win_sum_nxt = '0;
            end else begin
              state_nxt = SEARCH;
            end
          end else begin
            sym_nxt = sym_cnt + SYMW'(1);
          end
        end
        LOCKED: begin
          lfsr_nxt  = lfsr_step;
          count_en  = 1'b1;
          pulse_nxt = (nerr != 2'd0);
          if (win_cnt == WW'(LOL_WINDOW - 1)) begin
            win_nxt     = '0;
            win_sum_nxt = '0;
          end else begin
            win_nxt     = win_cnt + WW'(1);
            win_sum_nxt = win_acc;
          end
          if (win_acc >= SW'(LOL_MAX_ERR)) begin
            state_nxt = SEARCH;
            sym_nxt   = '0;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  logic [CNT_WIDTH:0]   bc_ext, ec_ext;
  logic [CNT_WIDTH-1:0] bc_nxt, ec_nxt;
  assign bc_ext = {1'b0, bit_count} + (CNT_WIDTH+1)'(2);
  assign ec_ext = {1'b0, err_count} + {{(CNT_WIDTH-1){1'b0}}, nerr};
  assign bc_nxt = bc_ext[CNT_WIDTH] ? CNT_MAX : bc_ext[CNT_WIDTH-1:0];
  assign ec_nxt = ec_ext[CNT_WIDTH] ? CNT_MAX : ec_ext[CNT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= SEARCH;
      lfsr      <= '0;
      sym_cnt   <= '0;
      verr      <= '0;
      win_cnt   <= '0;
      win_sum   <= '0;
      err_pulse <= 1'b0;
      bit_count <= '0;
      err_count <= '0;
    end else begin
      state_q   <= state_nxt;
      lfsr      <= lfsr_nxt;
      sym_cnt   <= sym_nxt;
      verr      <= verr_nxt;
      win_cnt   <= win_nxt;
      win_sum   <= win_sum_nxt;
      err_pulse <= pulse_nxt;
      // Saturated bit_count freezes both counters so the BER ratio stays meaningful.
      if (clr_cnt) begin
        bit_count <= '0;
        err_count <= '0;
      end else if (count_en && bit_count != CNT_MAX) begin
        bit_count <= bc_nxt;
        err_count <= ec_nxt;
      end
    end
  end

  assign locked = (state_q == LOCKED);
  assign state  = state_q;

endmodule

// File: tb/tb_qpsk_prbs_ber_checker.sv
// Directed-sequence bench with randomized sample magnitudes/gaps, checked every cycle
// against a bit-queue reference model for a 32-bit-counter and a 4-bit-counter instance.
`timescale 1ns/1ps
module tb_qpsk_prbs_ber_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, clr_cnt;
  logic [15:0] in_I, in_Q;
  logic        locked, err_pulse, locked4, err_pulse4;
  logic [1:0]  state, state4;
  logic [31:0] bit_count, err_count;
  logic [3:0]  bit_count4, err_count4;

  qpsk_prbs_ber_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_I(in_I), .in_Q(in_Q),
    .clr_cnt(clr_cnt), .locked(locked), .state(state), .err_pulse(err_pulse),
    .bit_count(bit_count), .err_count(err_count));

  qpsk_prbs_ber_checker #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_I(in_I), .in_Q(in_Q),
    .clr_cnt(clr_cnt), .locked(locked4), .state(state4), .err_pulse(err_pulse4),
    .bit_count(bit_count4), .err_count(err_count4));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: mode 0/1/2, bit history queue (last 9 bits, oldest first).
  int     m_mode, m_sym, m_verr, m_wc, m_ws;
  bit     m_pulse;
  bit     rxq[$];
  bit     txq[$];
  longint bc32, ec32, bc4, ec4;
  localparam longint MAX32 = 64'd4294967295;
  localparam longint MAX4  = 64'd15;

  task automatic push_bit(inout bit q[$], input bit b);
    q.push_back(b);
    void'(q.pop_front());
  endtask

  // Next PRBS9 bit from history: b[n] = b[n-9] ^ b[n-5].
  task automatic next_bit(inout bit q[$], output bit b);
    b = q[0] ^ q[4];
    push_bit(q, b);
  endtask

  task automatic model_reset();
    m_mode = 0; m_sym = 0; m_verr = 0; m_wc = 0; m_ws = 0; m_pulse = 0;
    bc32 = 0; ec32 = 0; bc4 = 0; ec4 = 0;
    rxq = {};
    for (int i = 0; i < 9; i++) rxq.push_back(1'b0);
  endtask

  task automatic cnt_upd(inout longint bc, inout longint ec, input longint mx, input int n);
    if (bc != mx) begin
      bc = (bc + 2 > mx) ? mx : bc + 2;
      ec = (ec + n > mx) ? mx : ec + n;
    end
  endtask

  task automatic model_sym(input bit bi, input bit bq);
    bit e1, e2;
    int n, any;
    case (m_mode)
      0: begin
        push_bit(rxq, bi);
        push_bit(rxq, bq);
        m_sym++;
        if (m_sym == 5) begin
          m_sym = 0;
          any = 0;
          foreach (rxq[k]) any += rxq[k];
          if (any != 0) begin m_mode = 1; m_verr = 0; end
        end
      end
      1: begin
        next_bit(rxq, e1); next_bit(rxq, e2);
        m_verr += int'(bi != e1) + int'(bq != e2);
        m_sym++;
        if (m_sym == 32) begin
          m_sym = 0;
          m_mode = (m_verr <= 2) ? 2 : 0;
          m_wc = 0; m_ws = 0;
        end
      end
      default: begin
        next_bit(rxq, e1); next_bit(rxq, e2);
        n = int'(bi != e1) + int'(bq != e2);
        m_pulse = (n > 0);
        cnt_upd(bc32, ec32, MAX32, n);
        cnt_upd(bc4, ec4, MAX4, n);
        m_ws += n;
        m_wc++;
        if (m_ws >= 16) begin m_mode = 0; m_sym = 0; end
        if (m_wc == 64) begin m_wc = 0; m_ws = 0; end
      end
    endcase
  endtask

  task automatic compare_all();
    chk("state", state, m_mode);
    chk("locked", locked, m_mode == 2);
    chk("err_pulse", err_pulse, m_pulse);
    chk("bit_count", bit_count, bc32);
    chk("err_count", err_count, ec32);
    chk("state4", state4, m_mode);
    chk("err_pulse4", err_pulse4, m_pulse);
    chk("bit_count4", bit_count4, bc4);
    chk("err_count4", err_count4, ec4);
  endtask

  function automatic logic [15:0] level(input bit b);
    logic [15:0] mag;
    mag = 16'($urandom_range(1, 32767));
    return b ? -mag : mag;
  endfunction

  task automatic step(input bit v, input bit bi, input bit bq, input bit clr);
    in_valid = v; in_I = level(bi); in_Q = level(bq); clr_cnt = clr;
    @(posedge clk);
    m_pulse = 0;
    if (v) model_sym(bi, bq);
    if (clr) begin bc32 = 0; ec32 = 0; bc4 = 0; ec4 = 0; end
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) begin
      in_valid = 1'($urandom); in_I = 16'($urandom); in_Q = 16'($urandom); clr_cnt = 1'b0;
      @(posedge clk);
    end
    model_reset();
    #1;
    compare_all();
    rst = 1'b1;
  endtask

  task automatic tx_reset();
    txq = {};
    for (int i = 0; i < 9; i++) txq.push_back(1'b1);
  endtask

  task automatic tx_sym(output bit b1, output bit b2);
    next_bit(txq, b1);
    next_bit(txq, b2);
  endtask

  initial begin
    bit b1, b2, flip;
    int nsym, budget;
    longint held_bc, held_ec;
    rst = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0; in_I = '0; in_Q = '0;

    // Reset state
    do_reset(3);
    chk("reset_state", state, 0);

    // Clean PRBS9, valid every cycle
    tx_reset();
    for (int i = 1; i <= 37; i++) begin
      tx_sym(b1, b2);
      step(1, b1, b2, 0);
      if (i == 36) chk("not_locked_at_36", locked, 0);
    end
    chk("locked_at_37", locked, 1);
    for (int i = 0; i < 100; i++) begin tx_sym(b1, b2); step(1, b1, b2, 0); end
    chk("bc_200", bit_count, 200);
    chk("ec_0", err_count, 0);
    chk("bc4_saturated", bit_count4, 15);

    // Single I flip every 100th symbol
    for (int i = 1; i <= 300; i++) begin
      tx_sym(b1, b2);
      flip = (i % 100 == 0);
      step(1, b1 ^ flip, b2, 0);
      if (flip) chk("pulse_on_flip", err_pulse, 1);
      else if (i % 100 == 1) chk("pulse_one_cycle", err_pulse, 0);
    end
    chk("ec_3", err_count, 3);
    chk("bc_800", bit_count, 800);
    chk("locked_hold", locked, 1);
    chk("ec4_frozen", err_count4, 0);

    // Valid 1-in-3 with a mid-operation reset beforehand
    do_reset(2);
    tx_reset();
    nsym = 0;
    for (int i = 0; i < 137 * 3; i++) begin
      if (i % 3 == 0) begin
        tx_sym(b1, b2);
        step(1, b1, b2, 0);
        nsym++;
        if (nsym == 36) chk("gap_not_locked_36", locked, 0);
        if (nsym == 37) chk("gap_locked_37", locked, 1);
      end else begin
        step(0, 1'($urandom), 1'($urandom), 0);
      end
    end
    chk("gap_bc_200", bit_count, 200);
    chk("gap_ec_0", err_count, 0);

    // Random bits: loss of lock within one window, counts hold afterwards
    budget = 0;
    while (m_mode == 2 && budget < 64) begin
      step(1, 1'($urandom), 1'($urandom), 0);
      budget++;
    end
    chk("lol_within_64", locked, 0);
    held_bc = bc32; held_ec = ec32;
    for (int i = 0; i < 40; i++) step(1, 1'($urandom), 1'($urandom), 0);
    chk("bc_held", bit_count, held_bc);
    chk("ec_held", err_count, held_ec);

    // All-zero input never leaves SEARCH
    do_reset(1);
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'b1; in_I = 16'd100; in_Q = 16'd100; clr_cnt = 1'b0;
      @(posedge clk);
      model_sym(0, 0);
      #1;
      chk("zero_search", state, 0);
    end

    // clr_cnt on the same cycle as an error symbol
    do_reset(1);
    tx_reset();
    for (int i = 0; i < 50; i++) begin tx_sym(b1, b2); step(1, b1, b2, 0); end
    tx_sym(b1, b2);
    step(1, ~b1, ~b2, 1);
    chk("clr_bc", bit_count, 0);
    chk("clr_ec", err_count, 0);
    chk("clr_keeps_lock", locked, 1);
    tx_sym(b1, b2);
    step(1, b1, b2, 0);
    chk("after_clr_bc", bit_count, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
